// File: rtl/pattern_sequencer.sv
// Chooses the dot-matrix pattern_id from debounced buttons or a timed auto-play.
// Define PATSEQ_PINGPONG_EN to make auto-play bounce between ids 1 and 15 instead of wrapping.
module pattern_sequencer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_mode,
    input  logic [1:0] speed,
    output logic [3:0] pattern_id,
    output logic       auto_mode,
    output logic       step_pulse
);

    localparam int CW = $clog2(4 * TICK_DIV);

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_MANUAL,
        ST_AUTO
    } state_t;

    // Button bit order in the synchronizer vectors: {mode, prev, next}
    logic [2:0]    s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [2:0]    btn_rise;
    state_t        state_q, state_d;
    logic [3:0]    id_q, id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    speed_q, speed_d;
    logic          auto_q, auto_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] term;
    logic          ev_next, ev_prev, ev_mode;
`ifdef PATSEQ_PINGPONG_EN
    logic          dir_q, dir_d;
`endif

    function automatic logic [3:0] wrap_up(input logic [3:0] id);
        return (id == 4'd15) ? 4'd1 : id + 4'd1;
    endfunction

    function automatic logic [3:0] wrap_down(input logic [3:0] id);
        return (id == 4'd1) ? 4'd15 : id - 4'd1;
    endfunction

    assign btn_rise = s2_q & ~s3_q;
    // Simultaneous next and prev cancel each other; mode is resolved first below.
    assign ev_next  = btn_rise[0] & ~btn_rise[1];
    assign ev_prev  = btn_rise[1] & ~btn_rise[0];
    assign ev_mode  = btn_rise[2];
    // Terminal count uses the speed latched at the last counter clear.
    assign term     = CW'((32'(speed_q) + 32'd1) * 32'(TICK_DIV) - 32'd1);

    always_comb begin
        s1_d    = {btn_mode, btn_prev, btn_next};
        s2_d    = s1_q;
        s3_d    = s2_q;
        state_d = state_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        speed_d = speed_q;
`ifdef PATSEQ_PINGPONG_EN
        dir_d   = dir_q;
`endif
        unique case (state_q)
            ST_BLANK: begin
                if (ev_mode || ev_next) begin
                    state_d = ST_MANUAL;
                    id_d    = 4'd1;
                end else if (ev_prev) begin
                    state_d = ST_MANUAL;
                    id_d    = 4'd15;
                end
            end
            ST_MANUAL: begin
                if (ev_mode) begin
                    state_d = ST_AUTO;
                    cnt_d   = '0;
                    speed_d = speed;
`ifdef PATSEQ_PINGPONG_EN
                    dir_d   = 1'b1;
`endif
                end else if (ev_next) begin
                    id_d = wrap_up(id_q);
                end else if (ev_prev) begin
                    id_d = wrap_down(id_q);
                end
            end
            ST_AUTO: begin
                if (ev_mode) begin
                    state_d = ST_MANUAL;
                    cnt_d   = '0;
                end else if (ev_next || ev_prev) begin
                    id_d    = ev_next ? wrap_up(id_q) : wrap_down(id_q);
                    cnt_d   = '0;
                    speed_d = speed;
                end else if (cnt_q == term) begin
                    cnt_d   = '0;
                    speed_d = speed;
`ifdef PATSEQ_PINGPONG_EN
                    if (dir_q) begin
                        if (id_q == 4'd15) begin
                            id_d  = 4'd14;
                            dir_d = 1'b0;
                        end else begin
                            id_d = id_q + 4'd1;
                        end
                    end else begin
                        if (id_q == 4'd1) begin
                            id_d  = 4'd2;
                            dir_d = 1'b1;
                        end else begin
                            id_d = id_q - 4'd1;
                        end
                    end
`else
                    id_d = wrap_up(id_q);
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                id_d    = 4'd0;
                cnt_d   = '0;
            end
        endcase
        auto_d  = (state_d == ST_AUTO);
        pulse_d = (id_d != id_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            state_q <= ST_BLANK;
            id_q    <= 4'd0;
            cnt_q   <= '0;
            speed_q <= 2'd0;
            auto_q  <= 1'b0;
            pulse_q <= 1'b0;
`ifdef PATSEQ_PINGPONG_EN
            dir_q   <= 1'b1;
`endif
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            speed_q <= speed_d;
            auto_q  <= auto_d;
            pulse_q <= pulse_d;
`ifdef PATSEQ_PINGPONG_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign pattern_id = id_q;
    assign auto_mode  = auto_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Randomized bench for pattern_sequencer with an event-level reference model and directed checks.
module tb_pattern_sequencer;

    localparam int TICK_DIV = 4;
`ifdef PATSEQ_PINGPONG_EN
    localparam int EXP_ID2 = 14;
    localparam int EXP_ID3 = 13;
`else
    localparam int EXP_ID2 = 1;
    localparam int EXP_ID3 = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_next, btn_prev, btn_mode;
    logic [1:0] speed;
    logic [3:0] pattern_id;
    logic       auto_mode, step_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 0;

    pattern_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .btn_mode   (btn_mode),
        .speed      (speed),
        .pattern_id (pattern_id),
        .auto_mode  (auto_mode),
        .step_pulse (step_pulse)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on button samples and ids directly: an action fires two clocks after
    // the first clock that sees a button high, and auto-play advances once per period.
    int         m_id, m_cnt, m_period, prev_id;
    bit         m_auto, m_dir, m_pulse;
    bit         nx, pv, md;
    logic [2:0] hist_q[$];
    logic [2:0] rise;

    function automatic int up1(input int id);
        return (id == 15) ? 1 : id + 1;
    endfunction

    function automatic int dn1(input int id);
        return (id == 1) ? 15 : id - 1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_id = 0; m_auto = 0; m_pulse = 0; m_cnt = 0;
            m_period = TICK_DIV; m_dir = 1;
            hist_q = '{3'b000, 3'b000, 3'b000, 3'b000};
        end else begin
            prev_id = m_id;
            hist_q.push_front({btn_mode, btn_prev, btn_next});
            void'(hist_q.pop_back());
            rise = hist_q[2] & ~hist_q[3];
            md = rise[2];
            nx = rise[0] && !rise[1];
            pv = rise[1] && !rise[0];
            if (m_id == 0) begin
                if (md || nx) m_id = 1;
                else if (pv) m_id = 15;
            end else if (!m_auto) begin
                if (md) begin
                    m_auto = 1; m_cnt = 0; m_dir = 1;
                    m_period = (int'(speed) + 1) * TICK_DIV;
                end else if (nx) m_id = up1(m_id);
                else if (pv) m_id = dn1(m_id);
            end else begin
                if (md) begin
                    m_auto = 0;
                end else if (nx || pv) begin
                    m_id = nx ? up1(m_id) : dn1(m_id);
                    m_cnt = 0;
                    m_period = (int'(speed) + 1) * TICK_DIV;
                end else begin
                    m_cnt++;
                    if (m_cnt == m_period) begin
`ifdef PATSEQ_PINGPONG_EN
                        if (m_dir && m_id == 15) m_dir = 0;
                        else if (!m_dir && m_id == 1) m_dir = 1;
                        m_id = m_dir ? m_id + 1 : m_id - 1;
`else
                        m_id = up1(m_id);
`endif
                        m_cnt = 0;
                        m_period = (int'(speed) + 1) * TICK_DIV;
                    end
                end
            end
            m_pulse = (m_id != prev_id);
        end
    end

    // Cycle-by-cycle scoreboard against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst && chk_en) begin
            check("model_pattern_id", pattern_id, m_id);
            check("model_auto_mode", auto_mode, m_auto);
            check("model_step_pulse", step_pulse, m_pulse);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic press(input logic [2:0] m);
        @(negedge clk);
        {btn_mode, btn_prev, btn_next} = m;
        @(negedge clk);
        {btn_mode, btn_prev, btn_next} = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_pulse(output int t);
        t = -1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (step_pulse) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("pulse_timeout", 0, 1);
    endtask

    task automatic goto_manual_id(input int target);
        for (int g = 0; g < 20 && m_id != target; g++) press(3'b001);
    endtask

    // ---------------- stimulus ----------------
    int t0, t1, t2, t3;
    bit seen;

    initial begin
        rst = 1'b0;
        btn_next = 1'b0; btn_prev = 1'b0; btn_mode = 1'b0;
        speed = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_pattern_id", pattern_id, 0);
        check("reset_auto_mode", auto_mode, 0);
        check("reset_step_pulse", step_pulse, 0);
        rst = 1'b1;
        chk_en = 1;

        // Button latency: high before edge k, update after edge k+2.
        @(negedge clk);
        btn_next = 1'b1;
        @(negedge clk);
        btn_next = 1'b0;
        @(posedge clk); #1;
        check("latency_early_id", pattern_id, 0);
        @(posedge clk); #1;
        check("latency_id", pattern_id, 1);
        check("latency_pulse", step_pulse, 1);
        @(posedge clk); #1;
        check("pulse_one_cycle", step_pulse, 0);
        press(3'b001);
        check("second_next", pattern_id, 2);

        // Wrap behaviour from BLANK and MANUAL.
        do_reset();
        press(3'b010);
        check("blank_prev", pattern_id, 15);
        press(3'b001);
        check("wrap_up", pattern_id, 1);
        press(3'b010);
        check("wrap_down", pattern_id, 15);

        // Same-cycle conflicts at id 7.
        repeat (7) press(3'b001);
        check("reach_7", pattern_id, 7);
        press(3'b011);
        check("next_prev_ignored", pattern_id, 7);
        press(3'b101);
        check("mode_wins_auto", auto_mode, 1);
        check("mode_wins_id", pattern_id, 7);

        // Auto-play timing from id 14 and a mid-period speed change.
        press(3'b100);
        goto_manual_id(14);
        check("reach_14", pattern_id, 14);
        @(negedge clk);
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (auto_mode) begin
                seen = 1;
                break;
            end
        end
        check("auto_rise_seen", seen, 1);
        t0 = cyc;
        wait_pulse(t1);
        check("first_auto_gap", t1 - t0, 4);
        check("first_auto_id", pattern_id, 15);
        @(negedge clk);
        @(negedge clk);
        speed = 2'd3;
        wait_pulse(t2);
        check("gap_before_speed", t2 - t1, 4);
        check("second_auto_id", pattern_id, EXP_ID2);
        wait_pulse(t3);
        check("gap_after_speed", t3 - t2, 16);
        check("third_auto_id", pattern_id, EXP_ID3);

        // Asynchronous reset while in AUTO at id 9.
        speed = 2'd0;
        press(3'b100);
        goto_manual_id(7);
        press(3'b100);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_id == 9) begin
                seen = 1;
                break;
            end
        end
        check("auto_reached_9", pattern_id, 9);
        #2 rst = 1'b0;
        #1;
        check("async_rst_id", pattern_id, 0);
        check("async_rst_auto", auto_mode, 0);
        check("async_rst_pulse", step_pulse, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("idle_after_reset_id", pattern_id, 0);
        check("idle_after_reset_auto", auto_mode, 0);

        // Randomized button traffic, scoreboarded every cycle.
        for (int i = 0; i < 500; i++) begin
            int hold, gap;
            logic [2:0] m;
            if (i == 250) begin
                @(negedge clk);
                btn_next = 1'b1;
                #2 rst = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b1;
                repeat (5) @(negedge clk);
                check("held_through_reset", pattern_id, 1);
                btn_next = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) speed = 2'($urandom_range(0, 3));
            m = {($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            hold = $urandom_range(1, 3);
            gap = $urandom_range(0, 8);
            @(negedge clk);
            {btn_mode, btn_prev, btn_next} = m;
            repeat (hold) @(negedge clk);
            {btn_mode, btn_prev, btn_next} = 3'b000;
            repeat (gap) @(negedge clk);
        end
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Controller that chooses which pattern the 8×8 dot-matrix display driver shows, by generating its 4-bit `pattern_id`. It supports manual stepping from push buttons and an auto-play mode with a selectable period. It sits between the board's button inputs and the display driver's `pattern_id` input. Pattern 0 is the blank frame; patterns 1–15 are the library.

## Interface
- `TICK_DIV`, default 50_000_000, clocks per base auto-play period; must be ≥ 2.
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `btn_next`  in  1  raw button: next pattern; asynchronous, clean (debounced externally)
- `btn_prev`  in  1  raw button: previous pattern; asynchronous, clean
- `btn_mode`  in  1  raw button: toggle manual/auto; asynchronous, clean
- `speed`  in  2  auto-play period multiplier; period = (`speed`+1)·`TICK_DIV` clocks
- `pattern_id`  out  4  pattern selected for the display driver
- `auto_mode`  out  1  1 while in AUTO
- `step_pulse`  out  1  one-cycle pulse on every `pattern_id` change

## Operation
- Each button passes through a 2-FF synchronizer (s1, s2) and a delay FF (s3); edge = s2 & ~s3. Only rising edges act. Holding a button produces no further edges.
- States:
  - BLANK: `pattern_id`=0.
  - MANUAL: `pattern_id` in 1..15.
  - AUTO: `pattern_id` in 1..15, with the period counter running.
- BLANK:
  - next or mode edge → MANUAL with id 1.
  - prev edge → MANUAL with id 15.
- MANUAL:
  - next: id+1, wrapping 15→1.
  - prev: id−1, wrapping 1→15.
  - mode edge → AUTO; the counter clears to 0 and the id is unchanged.
- AUTO:
  - When the counter reaches period−1, id advances as for next and the counter clears.
  - next/prev edge steps the id immediately and clears the counter.
  - mode edge → MANUAL; the counter holds 0 and the id is unchanged.
- next and prev edges in the same cycle: both are ignored, with no pulse.
- A mode edge in the same cycle as next/prev: mode wins and the step is dropped.
- `speed` is sampled when the counter clears. A change mid-period takes effect from the next period.
- Counter width is `$clog2(4*TICK_DIV)`. There is no overflow, because the terminal value is at most 4·`TICK_DIV`−1.
- `step_pulse` is asserted in the same cycle as the `pattern_id` update. It also fires on BLANK→MANUAL. It does not fire on a mode change with an unchanged id.

## Timing
- Reset values: `pattern_id`=0, `auto_mode`=0, `step_pulse`=0, state BLANK, counter 0, all synchronizer FFs 0.
- Reset mid-operation returns to BLANK immediately and asynchronously. Buttons held through reset release produce an edge once they are synchronized, since s3=0.
- Button latency: a button high before clock edge k gives an updated `pattern_id` and `step_pulse`=1 after edge k+2.
- Auto period: with a constant `speed`, consecutive `step_pulse`s are exactly (`speed`+1)·`TICK_DIV` clocks apart.
- First auto step: occurs (`speed`+1)·`TICK_DIV` clocks after the cycle in which `auto_mode` rises.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `PATSEQ_PINGPONG_EN`: when defined, AUTO reverses direction at the ends instead of wrapping.
  - A direction bit starts at up on entry to AUTO.
  - Sequence is …14, 15, 14, …, 2, 1, 2, …
  - Manual next/prev in AUTO still wrap as in MANUAL and do not change the direction bit.
- When undefined, AUTO always wraps 15→1 and the direction logic is absent.

## Test plan
- Reset, then pulse `btn_next` → `pattern_id` goes 0→1 at edge k+2 with `step_pulse` high for exactly 1 cycle. A second next gives 2.
- Reset, then `btn_prev` → id 15. Then `btn_next` ×1 → 1 (wrap). From 1, `btn_prev` → 15.
- `TICK_DIV`=4, `speed`=0, enter AUTO at id 14 → id 15, then 1, with steps 4 clocks apart. Set `speed`=3 mid-period → current step still after 4 clocks, following steps 16 clocks apart.
- Assert `btn_next` and `btn_prev` in the same cycle in MANUAL at id 7 → id stays 7 and `step_pulse` stays 0. Assert `btn_mode` with `btn_next` → `auto_mode`=1 and id stays 7.
- AUTO at id 9: assert `rst` low between clocks → `pattern_id`=0 and `auto_mode`=0 immediately. After release, no step occurs until a button edge.
- With `PATSEQ_PINGPONG_EN`, `TICK_DIV`=4, AUTO from id 14 → 15, 14, 13. Without it → 15, 1, 2.
